// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter: round-robin share of one AND/NAND gate unit between two requesters
module gate_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_op,
    output logic [1:0]         req_ready,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_id,
    input  logic               rsp_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   op_cnt0,
    output logic [CNT_W-1:0]   op_cnt1
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             op_q, op_d, id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             gnt_vld, gnt_id;

    // Priority goes to rr_ptr; the other requester wins only when rr_ptr is idle.
    always_comb begin
        gnt_vld     = |req_valid;
        gnt_id      = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        req_ready   = (state_q == IDLE && rst_n && gnt_vld) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        if (state_q == IDLE) begin
            if (gnt_vld) begin
                a_d     = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                b_d     = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                op_d    = req_op[gnt_id];
                id_d    = gnt_id;
                state_d = EXEC;
            end
        end else if (state_q == EXEC) begin
            rsp_data_d  = op_q ? ~(a_q & b_q) : (a_q & b_q);
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
        end else if (state_q == RESP) begin
            if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                cnt0_d      = rsp_id_q ? cnt0_q : cnt0_q + CNT_W'(1);
                cnt1_d      = rsp_id_q ? cnt1_q + CNT_W'(1) : cnt1_q;
                rr_ptr_d    = ~rsp_id_q;
                state_d     = IDLE;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = state_q != IDLE;
    assign op_cnt0   = cnt0_q;
    assign op_cnt1   = cnt1_q;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb_gate_unit_arbiter: directed scenarios for the shared AND/NAND gate arbiter
module tb_gate_unit_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [7:0]  rsp_data, op_cnt0, op_cnt1;
    logic [1:0]  w_req_valid, w_req_ready, w_req_a, w_req_b, w_req_op;
    logic        w_rsp_valid, w_rsp_data, w_rsp_id, w_rsp_ready, w_busy;
    logic [1:0]  w_cnt0, w_cnt1;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    gate_unit_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy), .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
    );

    gate_unit_arbiter #(.WIDTH(1), .CNT_W(2)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_a(w_req_a), .req_b(w_req_b),
        .req_op(w_req_op), .req_ready(w_req_ready), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
        .rsp_id(w_rsp_id), .rsp_ready(w_rsp_ready), .busy(w_busy), .op_cnt0(w_cnt0), .op_cnt1(w_cnt1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = 2'b00;
        w_req_valid = 2'b00;
        rsp_ready = 1'b1;
        w_rsp_ready = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_a = 16'hFFFF;
        req_b = 16'hFFFF;
        req_op = 2'b00;
        rsp_ready = 1'b1;
        w_req_valid = 2'b00;
        w_rsp_ready = 1'b1;
        tick;
        tick;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++;
        if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        n_cmp++;
        if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if ({op_cnt0, op_cnt1} !== 16'h0000) begin n_err++; $display("FAIL reset_cnt got %h/%h want 00/00", op_cnt0, op_cnt1); end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op(input bit id, input logic [7:0] a, input logic [7:0] b, input bit op,
                                  input logic [7:0] exp_data, input logic [7:0] exp_cnt);
        rsp_ready = 1'b1;
        req_a = id ? {a, 8'h00} : {8'h00, a};
        req_b = id ? {b, 8'h00} : {8'h00, b};
        req_op = id ? {op, 1'b0} : {1'b0, op};
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        n_cmp++;
        if (req_ready !== req_valid) begin n_err++; $display("FAIL single_ready id%0d got %b want %b", id, req_ready, req_valid); end
        tick;
        req_valid = 2'b00;
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL single_exec id%0d busy/valid got %b want 10", id, {busy, rsp_valid}); end
        tick;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, id, exp_data})
            begin n_err++; $display("FAIL single_rsp id%0d got v%b id%b %h want v1 id%b %h", id, rsp_valid, rsp_id, rsp_data, id, exp_data); end
        tick;
        n_cmp++;
        if ({rsp_valid, busy, (id ? op_cnt1 : op_cnt0)} !== {2'b00, exp_cnt})
            begin n_err++; $display("FAIL single_done id%0d got v%b b%b cnt%0d want v0 b0 cnt%0d", id, rsp_valid, busy, id ? op_cnt1 : op_cnt0, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_ids;
        int waits;
        do_reset;
        exp_ids = 2'b10;
        req_a = 16'hF0_3C;
        req_b = 16'h33_0F;
        req_op = 2'b10;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            waits = 0;
            while (!rsp_valid && waits < 10) begin
                tick;
                waits++;
            end
            n_cmp++;
            if (!rsp_valid) begin n_err++; $display("FAIL b2b_timeout op%0d rsp_valid got 0 want 1", k); end
            n_cmp++;
            if ({rsp_id, rsp_data} !== {exp_ids[k%2], exp_ids[k%2] ? 8'hCF : 8'h0C})
                begin n_err++; $display("FAIL b2b_rsp op%0d got id%b %h want id%b %h", k, rsp_id, rsp_data, exp_ids[k%2], exp_ids[k%2] ? 8'hCF : 8'h0C); end
            if (k > 0) begin
                n_cmp++;
                if (waits !== 2) begin n_err++; $display("FAIL b2b_gap op%0d got %0d want 2", k, waits); end
            end
            tick;
        end
        req_valid = 2'b00;
        n_cmp++;
        if ({op_cnt0, op_cnt1} !== {8'd2, 8'd2}) begin n_err++; $display("FAIL b2b_cnt got %0d/%0d want 2/2", op_cnt0, op_cnt1); end
    endtask

    task automatic test_rsp_stall;
        do_reset;
        rsp_ready = 1'b0;
        req_a = 16'h00C3;
        req_b = 16'h00FF;
        req_op = 2'b01;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b11;
        req_a = 16'h5500;
        req_op = 2'b00;
        tick;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, busy, req_ready, rsp_data} !== {4'b1100, 8'h3C})
                begin n_err++; $display("FAIL stall_hold cyc%0d got v%b b%b rdy%b %h want v1 b1 rdy00 3c", i, rsp_valid, busy, req_ready, rsp_data); end
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        n_cmp++;
        if ({rsp_valid, op_cnt0} !== {1'b0, 8'd1}) begin n_err++; $display("FAIL stall_done got v%b cnt%0d want v0 cnt1", rsp_valid, op_cnt0); end
        n_cmp++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL stall_next_grant got %b want 10", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_op;
        do_reset;
        req_a = 16'h0F0F;
        req_b = 16'hFFFF;
        req_op = 2'b00;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        tick;
        tick;
        req_valid = 2'b10;
        tick;
        req_valid = 2'b00;
        n_cmp++;
        if ({busy, op_cnt0} !== {1'b1, 8'd1}) begin n_err++; $display("FAIL midrst_pre got b%b cnt%0d want b1 cnt1", busy, op_cnt0); end
        rst_n = 1'b0;
        tick;
        n_cmp++;
        if ({rsp_valid, busy, op_cnt0} !== {2'b00, 8'd0}) begin n_err++; $display("FAIL midrst_clear got v%b b%b cnt%0d want v0 b0 cnt0", rsp_valid, busy, op_cnt0); end
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL midrst_grant got %b want 01", req_ready); end
        tick;
        req_valid = 2'b00;
        tick;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 8'h0F}) begin n_err++; $display("FAIL midrst_rsp got v%b id%b %h want v1 id0 0f", rsp_valid, rsp_id, rsp_data); end
        tick;
    endtask

    task automatic test_width1;
        logic [7:0] exp_v;
        logic [2:0] c;
        exp_v = 8'b0110_1010;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            w_req_a = {1'b0, c[2]};
            w_req_b = {1'b0, c[1]};
            w_req_op = {1'b0, c[0]};
            w_req_valid = 2'b01;
            tick;
            w_req_valid = 2'b00;
            tick;
            n_cmp++;
            if ({w_rsp_valid, w_rsp_data} !== {1'b1, exp_v[i]})
                begin n_err++; $display("FAIL w1_combo abo=%b got v%b d%b want v1 d%b", c, w_rsp_valid, w_rsp_data, exp_v[i]); end
            tick;
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (w_cnt0 !== ((i == 2) ? 2'd3 : 2'd0)) begin n_err++; $display("FAIL w1_cnt_wrap op%0d got %0d want %0d", i, w_cnt0, (i == 2) ? 3 : 0); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_op(1'b0, 8'hA5, 8'h0F, 1'b0, 8'h05, 8'd1);
        test_single_op(1'b1, 8'hFF, 8'h0F, 1'b1, 8'hF0, 8'd1);
        test_back_to_back;
        test_rsp_stall;
        test_reset_mid_op;
        test_width1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
